booth_seq_mult: RTL

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

---
 rtl/booth_pkg.sv | 16 +
 rtl/booth_step.sv | 36 +++
 rtl/booth_seq_mult.sv | 115 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier.
// Holds the FSM state encoding and the counter sizing helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold WIDTH+1 steps plus the terminal zero.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M, then
// arithmetic right shift of {acc, Q, Q-1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] acc,
    input  logic [WIDTH:0] q,
    input  logic           qm1,
    input  logic [WIDTH:0] m,
    output logic [WIDTH:0] acc_nx,
    output logic [WIDTH:0] q_nx,
    output logic           qm1_nx
);

    logic [WIDTH+1:0] acc_ext;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;

    // The sum carries one guard bit so the shifted value keeps its true sign.
    always_comb begin
        acc_ext = {acc[WIDTH], acc};
        m_ext   = {m[WIDTH], m};
        sum     = acc_ext;
        unique case ({q[0], qm1})
            2'b10:   sum = acc_ext - m_ext;
            2'b01:   sum = acc_ext + m_ext;
            default: sum = acc_ext;
        endcase
        acc_nx = sum[WIDTH+1:1];
        q_nx   = {sum[0], q[WIDTH:1]};
        qm1_nx = q[0];
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier: WIDTH+1 steps, signed or unsigned.
// Result is registered and held until the next accepted start.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = cnt_width(WIDTH);
    localparam int XW = WIDTH + 1;

    state_t          state;
    state_t          state_nx;
    logic            accept;
    logic [XW-1:0]   m;
    logic [XW-1:0]   acc;
    logic [XW-1:0]   q;
    logic            qm1;
    logic [CW-1:0]   cnt;
    logic [XW-1:0]   acc_nx;
    logic [XW-1:0]   q_nx;
    logic            qm1_nx;
    logic            step_en;
    logic            finish;

    function automatic logic [XW-1:0] ext(
        input logic [WIDTH-1:0] v,
        input logic             s
    );
        return {s & v[WIDTH-1], v};
    endfunction

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc    (acc),
        .q      (q),
        .qm1    (qm1),
        .m      (m),
        .acc_nx (acc_nx),
        .q_nx   (q_nx),
        .qm1_nx (qm1_nx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and operand-accept decode.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign step_en = (state == RUN) && (cnt != '0);
    assign finish  = (state == RUN) && (cnt == '0);
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    // Datapath: capture, iterate, and latch the product on RUN->DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
            qm1 <= 1'b0;
            cnt <= '0;
            P   <= '0;
        end else if (accept) begin
            m   <= ext(A, signed_mode);
            q   <= ext(B, signed_mode);
            acc <= '0;
            qm1 <= 1'b0;
            cnt <= CW'(XW);
        end else if (step_en) begin
            acc <= acc_nx;
            q   <= q_nx;
            qm1 <= qm1_nx;
            cnt <= cnt - CW'(1);
        end else if (finish) begin
            P   <= {acc[WIDTH-2:0], q};
        end
    end

endmodule
